data_mem_responder: RTL and testbench

Memory-side responder for the CPU's MEM-stage load/store port. It accepts one word request at a time, models a fixed multi-cycle access latency, and returns a one-cycle acknowledge with read data. While a request is in flight it drives a stall back to the pipeline's hazard logic. It replaces the single-cycle data memory, so pipelined stalls can be exercised against realistic memory timing.

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the MEM-stage load/store port. It accepts one
// word request at a time, waits a fixed LATENCY, then returns a one-cycle
// ack with read data (or, for writes, an echo of the written word).
// While a request is outstanding, stall_o holds the pipeline.
//
// Optional feature macro: MEM_RESP_ALIGN_CHK_EN
//   defined   : a misaligned byte address (addr[1:0] != 0) is still timed
//               normally, but it is answered with err_o=1 and rdata_o=0,
//               and a misaligned write does not modify the array.
//   undefined : addr[1:0] is ignored and err_o is tied low.
//
// Handshake: the requester raises req_i and holds it high, with a stable
// payload, until it sees ack_o. The payload is captured on the acceptance
// edge (IDLE with req_i=1). Only the captured copy is used afterwards.
// ack_o is high for exactly one cycle per accepted request. A req_i that is
// still high in the ack cycle is not accepted until the following IDLE cycle.
//
// Debug: dbg_state_o / dbg_cnt_o expose the FSM state and the wait counter.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_cnt_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Number of WAIT cycles that still follow the first WAIT cycle.
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  // Captured request payload.
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Registered response.
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_err;

  // Storage array; intentionally not reset.
  logic [31:0] r_mem [DEPTH_WORDS];

  // Effective request fields. With LATENCY=1 the response is produced on
  // the acceptance edge itself, so the live inputs are used in IDLE and the
  // captured copy everywhere else.
  logic          w_accept;
  logic          w_enter_resp;
  logic          w_sel_we;
  logic [31:0]   w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [AW-1:0] w_index;
  logic          w_misaligned;
  logic          w_mem_we;

  // Select the live or captured request and derive the array index.
  always_comb begin
    w_accept     = (r_state == S_IDLE) && req_i;
    w_sel_we     = (r_state == S_IDLE) ? we_i    : r_we;
    w_sel_addr   = (r_state == S_IDLE) ? addr_i  : r_addr;
    w_sel_wdata  = (r_state == S_IDLE) ? wdata_i : r_wdata;
    w_index      = w_sel_addr[AW+1:2];
`ifdef MEM_RESP_ALIGN_CHK_EN
    w_misaligned = |w_sel_addr[1:0];
`else
    w_misaligned = 1'b0;
`endif
    w_enter_resp = ((r_state == S_IDLE) && req_i && (LATENCY == 1)) ||
                   ((r_state == S_WAIT) && (r_cnt == 4'd0));
    w_mem_we     = w_enter_resp && w_sel_we && !w_misaligned;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        // The ack cycle always returns to IDLE; a held req_i waits there.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request payload on the acceptance edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= we_i;
      r_addr  <= addr_i;
      r_wdata <= wdata_i;
    end
  end

  // Response registers: ack/err pulse on entry to RESP, rdata holds between acks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= w_enter_resp;
      r_err <= w_enter_resp && w_misaligned;
      if (w_enter_resp) begin
        if (w_misaligned) begin
          r_rdata <= 32'd0;
        end else if (w_sel_we) begin
          r_rdata <= w_sel_wdata;
        end else begin
          r_rdata <= r_mem[w_index];
        end
      end
    end
  end

  // Array write on entry to RESP; blocked while reset is asserted so an
  // interrupted write never lands.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_mem_we) begin
      r_mem[w_index] <= w_sel_wdata;
    end
  end

  assign ack_o       = r_ack;
  assign rdata_o     = r_rdata;
  assign err_o       = r_err;
  assign stall_o     = req_i & ~r_ack;
  assign dbg_state_o = r_state;
  assign dbg_cnt_o   = r_cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Two instances share clock and reset:
// inst 0 uses LATENCY=3, inst 1 uses LATENCY=1, both DEPTH_WORDS=256.
// A word-array reference model predicts read data, echoes and errors.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 3;
  localparam int LAT1  = 1;

  logic        clk;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        stall [2];
  logic [1:0]  dbg_state [2];
  logic [3:0]  dbg_cnt   [2];

  int checks;
  int failures;

  // Reference model: word contents and "has been written" flags per instance.
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_valid [2][DEPTH];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .ack_o(ack[0]), .rdata_o(rdata[0]),
    .err_o(err[0]), .stall_o(stall[0]), .dbg_state_o(dbg_state[0]),
    .dbg_cnt_o(dbg_cnt[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .ack_o(ack[1]), .rdata_o(rdata[1]),
    .err_o(err[1]), .stall_o(stall[1]), .dbg_state_o(dbg_state[1]),
    .dbg_cnt_o(dbg_cnt[1])
  );

  function automatic bit addr_misaligned(input logic [31:0] a);
`ifdef MEM_RESP_ALIGN_CHK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver / scoreboard ----------------
  // Issues one request on instance id starting at the current negedge, waits
  // for its ack, checks latency, stall, err and data, then drops req and
  // lets the responder return to IDLE.
  task automatic access(input int id, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit change_payload);
    int          lat;
    int          idx;
    int          cyc;
    bit          got;
    bit          known;
    bit          exp_e;
    logic [31:0] exp_d;
    lat   = (id == 0) ? LAT0 : LAT1;
    idx   = int'((a / 4) % DEPTH);
    exp_e = addr_misaligned(a);
    known = 1'b1;
    exp_d = 32'd0;
    if (exp_e) exp_d = 32'd0;
    else if (w) exp_d = d;
    else begin
      exp_d = m_mem[id][idx];
      known = m_valid[id][idx];
    end
    if (w && !exp_e) begin
      m_mem[id][idx]   = d;
      m_valid[id][idx] = 1'b1;
    end
    exp_q.push_back(exp_d);

    req[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = d;
    #1;
    checks++;
    if (stall[id] !== 1'b1) begin
      failures++;
      $display("FAIL stall_accept inst%0d addr=%h: got %b want 1", id, a, stall[id]);
    end
    got = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cyc = k;
      if (change_payload && k == 1) begin
        wdata[id] = 32'hFFFF_FFFF;
        addr[id]  = a ^ 32'h0000_0010;
      end
      if (ack[id] === 1'b1) begin
        got = 1'b1;
        break;
      end
      checks++;
      if (stall[id] !== 1'b1) begin
        failures++;
        $display("FAIL stall_wait inst%0d cyc=%0d: got %b want 1", id, k, stall[id]);
      end
    end
    exp_d = exp_q.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout inst%0d addr=%h: no ack in 40 cycles", id, a);
    end else begin
      checks++;
      if (cyc != lat) begin
        failures++;
        $display("FAIL latency inst%0d addr=%h: got %0d want %0d", id, a, cyc, lat);
      end
      checks++;
      if (err[id] !== exp_e) begin
        failures++;
        $display("FAIL err inst%0d addr=%h: got %b want %b", id, a, err[id], exp_e);
      end
      checks++;
      if (stall[id] !== 1'b0) begin
        failures++;
        $display("FAIL stall_ack inst%0d: got %b want 0", id, stall[id]);
      end
      if (known) begin
        checks++;
        if (rdata[id] !== exp_d) begin
          failures++;
          $display("FAIL rdata inst%0d addr=%h we=%b: got %h want %h", id, a, w, rdata[id], exp_d);
        end
      end
    end
    req[id] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack[id] !== 1'b0 || err[id] !== 1'b0) begin
      failures++;
      $display("FAIL ack_pulse inst%0d: ack=%b err=%b want 0 0", id, ack[id], err[id]);
    end
    if (known) begin
      checks++;
      if (rdata[id] !== exp_d) begin
        failures++;
        $display("FAIL rdata_hold inst%0d: got %h want %h", id, rdata[id], exp_d);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    req[0] = 1'b1; req[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      we[i] = 1'b1; addr[i] = 32'h100; wdata[i] = 32'h0BAD_F00D;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ack[i] !== 1'b0 || rdata[i] !== 32'd0 || err[i] !== 1'b0 ||
          dbg_state[i] !== 2'd0 || dbg_cnt[i] !== 4'd0) begin
        failures++;
        $display("FAIL reset_values inst%0d: ack=%b rdata=%h err=%b st=%0d cnt=%0d want 0", i,
                 ack[i], rdata[i], err[i], dbg_state[i], dbg_cnt[i]);
      end
    end
    checks++;
    if (stall[0] !== 1'b1 || stall[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b%b want 10", stall[0], stall[1]);
    end
    // Release with req held: acceptance on the first edge after release.
    rst_n = 1'b1;
    access(0, 1'b1, 32'h100, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_write_read;
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] e0;
    logic [31:0] e1;
    access(1, 1'b1, 32'h0, 32'h1111_0000, 1'b0);
    access(1, 1'b1, 32'h4, 32'h2222_0004, 1'b0);
    e0 = m_mem[1][0];
    e1 = m_mem[1][1];
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(negedge clk);
    checks++;
    if (ack[1] !== 1'b1 || rdata[1] !== e0) begin
      failures++;
      $display("FAIL b2b_first: ack=%b rdata=%h want 1 %h", ack[1], rdata[1], e0);
    end
    addr[1] = 32'h4;
    @(negedge clk);
    checks++;
    if (ack[1] !== 1'b0 || rdata[1] !== e0 || stall[1] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap: ack=%b rdata=%h stall=%b want 0 %h 1", ack[1], rdata[1], stall[1], e0);
    end
    @(negedge clk);
    checks++;
    if (ack[1] !== 1'b1 || rdata[1] !== e1) begin
      failures++;
      $display("FAIL b2b_second: ack=%b rdata=%h want 1 %h", ack[1], rdata[1], e1);
    end
    req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    access(0, 1'b1, 32'h400, 32'h0000_1234, 1'b0);
    access(0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_payload_change;
    access(0, 1'b1, 32'h8, 32'h0000_0055, 1'b1);
    access(0, 1'b0, 32'h8, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned;
    access(0, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b0);
    access(0, 1'b0, 32'h6, 32'h0, 1'b0);
    access(0, 1'b1, 32'h5, 32'h0BAD_BEEF, 1'b0);
    access(0, 1'b0, 32'h4, 32'h0, 1'b0);
    access(1, 1'b1, 32'h8, 32'h7777_8888, 1'b0);
    access(1, 1'b0, 32'hB, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_write;
    access(0, 1'b1, 32'h20, 32'h1111_2222, 1'b0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hA5A5_A5A5;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 1'b0 || rdata[0] !== 32'd0 || err[0] !== 1'b0 || dbg_state[0] !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: ack=%b rdata=%h err=%b st=%0d want 0 0 0 0",
               ack[0], rdata[0], err[0], dbg_state[0]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int          id;
      logic        w;
      logic [31:0] a;
      id = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      a  = $urandom() & 32'hFFFF_FFFC;
      if (!w && $urandom_range(0, 3) != 0) begin
        // Bias reads toward a small window that earlier writes have filled.
        a = {$urandom_range(0, 255), 2'b00};
        a = a & 32'h0000_003C;
      end
      access(id, w, a, $urandom(), 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0;
      for (int j = 0; j < DEPTH; j++) begin
        m_mem[i][j]   = 32'd0;
        m_valid[i][j] = 1'b0;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wrap();
    test_payload_change();
    test_misaligned();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
